spi_xfer_queue: RTL and testbench

- Transaction queue directly upstream and downstream of the SPI controller, entirely in the core_clk domain.
- Buffers host TX words in a FIFO and feeds them one at a time to the controller's tx_data/tx_valid/tx_ready interface.
- Captures each rx_data pulse into an RX FIFO for the host.
- Allows only one transfer in flight and pre-reserves RX space, so a controller result is never dropped in normal operation.

---
 rtl/spi_q_pkg.sv | 15 +
 rtl/spi_sync_fifo.sv | 65 ++++++
 rtl/spi_xfer_queue.sv | 142 ++++++++++++++
 tb/tb_spi_xfer_queue.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_q_pkg.sv
// Shared types and default sizing for the SPI transaction queue.
package spi_q_pkg;

  localparam int unsigned DEF_DEPTH     = 8;
  localparam int unsigned DEF_DW        = 32;
  localparam int unsigned DEF_START_TMO = 64;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    DRAIN     = 2'd3
  } q_state_e;

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO with occupancy count; push ignored when full, pop ignored when empty.
module spi_sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DW    = 32
) (
  input  logic                     core_clk,
  input  logic                     arst_n,
  input  logic                     push,
  input  logic [DW-1:0]            wdata,
  input  logic                     pop,
  output logic [DW-1:0]            rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          do_push, do_pop;

  assign full    = (level_q == LVL_FULL);
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define what is valid.
  always_ff @(posedge core_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/spi_xfer_queue.sv
// Host-side TX/RX queue in front of the SPI controller; one transfer in flight,
// RX space reserved before issue so a controller result is never dropped.
module spi_xfer_queue
  import spi_q_pkg::*;
#(
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned DW        = DEF_DW,
  parameter int unsigned START_TMO = DEF_START_TMO
) (
  input  logic                   core_clk,
  input  logic                   arst_n,
  input  logic                   enable,
  input  logic [DW-1:0]          host_wdata,
  input  logic                   host_wvalid,
  output logic                   host_wready,
  output logic [DW-1:0]          host_rdata,
  output logic                   host_rvalid,
  input  logic                   host_rready,
  output logic [DW-1:0]          tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  input  logic [DW-1:0]          rx_data,
  input  logic                   rx_valid,
  input  logic                   busy,
  output logic [$clog2(DEPTH):0] tx_level,
  output logic [$clog2(DEPTH):0] rx_level,
  output logic                   err_tmo,
  output logic                   err_ovf,
  input  logic                   clr_err,
  output logic                   q_busy
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam int unsigned CW = $clog2(START_TMO) + 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(START_TMO - 1);
  localparam logic [LW:0]   DEPTH_W  = (LW+1)'(DEPTH);

  q_state_e      state_q, state_d;
  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          err_tmo_q, err_tmo_d;
  logic          err_ovf_q, err_ovf_d;

  logic          tx_pop, tx_full, tx_empty;
  logic          rx_push, rx_full, rx_empty;
  logic [DW-1:0] tx_head, rx_head;
  logic          rx_pending, tmo_evt, ovf_evt;
  logic [LW:0]   rx_committed;

  spi_sync_fifo #(.DEPTH(DEPTH), .DW(DW)) u_tx_fifo (
    .core_clk (core_clk),
    .arst_n   (arst_n),
    .push     (host_wvalid && host_wready),
    .wdata    (host_wdata),
    .pop      (tx_pop),
    .rdata    (tx_head),
    .full     (tx_full),
    .empty    (tx_empty),
    .level    (tx_level)
  );

  spi_sync_fifo #(.DEPTH(DEPTH), .DW(DW)) u_rx_fifo (
    .core_clk (core_clk),
    .arst_n   (arst_n),
    .push     (rx_push),
    .wdata    (rx_data),
    .pop      (host_rready),
    .rdata    (rx_head),
    .full     (rx_full),
    .empty    (rx_empty),
    .level    (rx_level)
  );

  // Stored entries plus the slot held back for the transfer in flight.
  assign rx_pending   = (state_q == WAIT_DONE);
  assign rx_committed = {1'b0, rx_level} + (LW+1)'(rx_pending);

  always_comb begin
    state_d   = state_q;
    tmo_cnt_d = '0;
    tx_pop    = 1'b0;
    rx_push   = 1'b0;
    tmo_evt   = 1'b0;
    ovf_evt   = 1'b0;
    case (state_q)
      IDLE: begin
        ovf_evt = rx_valid;
        if (enable && !tx_empty && (rx_committed < DEPTH_W)) state_d = ISSUE;
      end
      ISSUE: begin
        ovf_evt = rx_valid;
        if (!tx_ready && busy) begin
          tx_pop  = 1'b1;
          state_d = WAIT_DONE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          tx_pop  = 1'b1;
          tmo_evt = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + CW'(1);
        end
      end
      WAIT_DONE: begin
        if (rx_valid) begin
          rx_push = !rx_full;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // A multi-cycle strobe is swallowed here so each transfer pushes once.
        if (!rx_valid && !busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    err_tmo_d = tmo_evt || (err_tmo_q && !clr_err);
    err_ovf_d = ovf_evt || (err_ovf_q && !clr_err);
  end

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= IDLE;
      tmo_cnt_q <= '0;
      err_tmo_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
      err_tmo_q <= err_tmo_d;
      err_ovf_q <= err_ovf_d;
    end
  end

  // Data outputs are forced to zero when not valid so they never expose stale storage.
  assign tx_valid    = (state_q == ISSUE);
  assign tx_data     = tx_valid ? tx_head : '0;
  assign host_wready = !tx_full;
  assign host_rvalid = !rx_empty;
  assign host_rdata  = host_rvalid ? rx_head : '0;
  assign err_tmo     = err_tmo_q;
  assign err_ovf     = err_ovf_q;
  assign q_busy      = (state_q != IDLE) || !tx_empty;

endmodule

// File: tb/tb_spi_xfer_queue.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
module tb_spi_xfer_queue;

  localparam int DEPTH = 8;
  localparam int DW    = 32;
  localparam int TMO   = 64;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          core_clk = 1'b0;
  logic          arst_n;
  logic          enable, host_wvalid, host_rready, tx_ready, rx_valid, busy, clr_err;
  logic [DW-1:0] host_wdata, rx_data;
  logic          host_wready, host_rvalid, tx_valid, err_tmo, err_ovf, q_busy;
  logic [DW-1:0] host_rdata, tx_data;
  logic [LW-1:0] tx_level, rx_level;

  always #5 core_clk = ~core_clk;

  spi_xfer_queue #(.DEPTH(DEPTH), .DW(DW), .START_TMO(TMO)) dut (
    .core_clk    (core_clk),
    .arst_n      (arst_n),
    .enable      (enable),
    .host_wdata  (host_wdata),
    .host_wvalid (host_wvalid),
    .host_wready (host_wready),
    .host_rdata  (host_rdata),
    .host_rvalid (host_rvalid),
    .host_rready (host_rready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .busy        (busy),
    .tx_level    (tx_level),
    .rx_level    (rx_level),
    .err_tmo     (err_tmo),
    .err_ovf     (err_ovf),
    .clr_err     (clr_err),
    .q_busy      (q_busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: queues hold FIFO contents, flags track the one transfer.
  logic [DW-1:0] m_tx [$];
  logic [DW-1:0] m_rx [$];
  bit m_offer, m_await, m_settle, m_err_tmo, m_err_ovf;
  int m_age;

  task automatic model_reset();
    m_tx.delete();
    m_rx.delete();
    m_offer = 0; m_await = 0; m_settle = 0;
    m_err_tmo = 0; m_err_ovf = 0; m_age = 0;
  endtask

  task automatic model_step();
    bit push_ok = host_wvalid && (m_tx.size() < DEPTH);
    bit pop_ok  = host_rready && (m_rx.size() > 0);
    bit rx_in   = 0;
    bit set_tmo = 0;
    bit set_ovf = 0;
    if (!m_offer && !m_await && !m_settle) begin
      set_ovf = rx_valid;
      if (enable && m_tx.size() > 0 && m_rx.size() < DEPTH) begin
        m_offer = 1;
        m_age   = 0;
      end
    end else if (m_offer) begin
      set_ovf = rx_valid;
      if (!tx_ready && busy) begin
        m_tx.delete(0);
        m_offer = 0;
        m_await = 1;
      end else if (m_age == TMO - 1) begin
        m_tx.delete(0);
        m_offer = 0;
        set_tmo = 1;
      end else begin
        m_age++;
      end
    end else if (m_await) begin
      if (rx_valid) begin
        rx_in    = 1;
        m_await  = 0;
        m_settle = 1;
      end
    end else if (!rx_valid && !busy) begin
      m_settle = 0;
    end
    if (pop_ok)  m_rx.delete(0);
    if (rx_in)   m_rx.push_back(rx_data);
    if (push_ok) m_tx.push_back(host_wdata);
    m_err_tmo = set_tmo || (m_err_tmo && !clr_err);
    m_err_ovf = set_ovf || (m_err_ovf && !clr_err);
  endtask

  always @(posedge core_clk) if (arst_n) model_step();

  always @(negedge core_clk) begin
    if (chk_en) begin
      check("host_wready", host_wready, m_tx.size() < DEPTH);
      check("tx_level",    tx_level,    m_tx.size());
      check("rx_level",    rx_level,    m_rx.size());
      check("tx_valid",    tx_valid,    m_offer);
      check("tx_data",     tx_data,     m_offer ? m_tx[0] : '0);
      check("host_rvalid", host_rvalid, m_rx.size() > 0);
      check("host_rdata",  host_rdata,  (m_rx.size() > 0) ? m_rx[0] : '0);
      check("err_tmo",     err_tmo,     m_err_tmo);
      check("err_ovf",     err_ovf,     m_err_ovf);
      check("q_busy",      q_busy,      m_offer || m_await || m_settle || m_tx.size() > 0);
    end
  end

  task automatic tick();
    @(negedge core_clk);
    #1;
  endtask

  task automatic do_xfer(input logic [DW-1:0] data);
    enable = 1; tick();
    enable = 0; tx_ready = 0; busy = 1; tick();
    rx_valid = 1; rx_data = data; tick();
    rx_valid = 0; busy = 0; tx_ready = 1; tick();
  endtask

  initial begin
    arst_n = 0; enable = 0; host_wvalid = 0; host_wdata = '0; host_rready = 0;
    tx_ready = 1; busy = 0; rx_valid = 0; rx_data = '0; clr_err = 0;
    model_reset();
    chk_en = 1;
    repeat (2) tick();
    check("rst_wready", host_wready, 1);
    check("rst_levels", {tx_level, rx_level}, 0);
    check("rst_flags", {tx_valid, host_rvalid, err_tmo, err_ovf, q_busy}, 0);
    arst_n = 1;
    tick();

    // Single issue: 2-cycle push-to-tx_valid, held until busy is seen.
    enable = 1; host_wvalid = 1; host_wdata = 32'hA5A5_0001; tick();
    host_wvalid = 0;
    check("push_level", tx_level, 1);
    check("push_no_valid", tx_valid, 0);
    tick();
    check("issue_valid", tx_valid, 1);
    check("issue_data", tx_data, 32'hA5A5_0001);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("issue_hold", {tx_valid, tx_data}, {1'b1, 32'hA5A5_0001});
    end
    enable = 0; tx_ready = 0; busy = 1; tick();
    check("accept_drop_valid", tx_valid, 0);
    check("accept_level", tx_level, 0);

    // Two-cycle rx_valid yields exactly one RX entry.
    rx_valid = 1; rx_data = 32'h1234_5678; tick();
    check("rx_one_level", rx_level, 1);
    check("rx_one_data", host_rdata, 32'h1234_5678);
    tick();
    check("rx_drain_level", rx_level, 1);
    rx_valid = 0; busy = 0; tx_ready = 1; tick();
    check("back_idle", q_busy, 0);
    host_rready = 1; tick();
    host_rready = 0;
    check("rx_popped", rx_level, 0);

    // TX fill: ninth word refused; pop at full with push pending only pops.
    host_wvalid = 1;
    for (int i = 0; i < 9; i++) begin
      host_wdata = 32'hC000_0000 + 32'(i);
      tick();
    end
    check("tx_full_level", tx_level, 8);
    check("tx_full_wready", host_wready, 0);
    enable = 1; tick();
    enable = 0; tx_ready = 0; busy = 1; tick();
    check("full_push_pop", tx_level, 7);
    host_wvalid = 0;
    rx_valid = 1; rx_data = 32'hD000_0000; tick();
    rx_valid = 0; busy = 0; tx_ready = 1; tick();

    // RX fill blocks issue; one host pop releases exactly one transfer.
    for (int i = 0; i < 7; i++) do_xfer(32'hE000_0000 + 32'(i));
    check("rx_full_level", rx_level, 8);
    host_wvalid = 1; host_wdata = 32'hF000_0001; tick();
    host_wdata = 32'hF000_0002; tick();
    host_wvalid = 0; enable = 1;
    repeat (3) begin
      tick();
      check("rx_full_blocks", tx_valid, 0);
    end
    host_rready = 1; tick();
    host_rready = 0;
    check("one_pop", rx_level, 7);
    tick();
    check("released_issue", tx_valid, 1);
    tx_ready = 0; busy = 1; tick();
    rx_valid = 1; rx_data = 32'hF0F0_0001; tick();
    rx_valid = 0; busy = 0; tx_ready = 1; tick();
    repeat (3) tick();
    check("only_one_issue", {tx_valid, tx_level, rx_level}, {1'b0, 4'd1, 4'd8});

    // Start timeout after exactly TMO cycles in ISSUE.
    host_rready = 1; tick();
    host_rready = 0; tick();
    check("tmo_issue", tx_valid, 1);
    enable = 0;
    repeat (TMO - 1) tick();
    check("tmo_not_yet", {tx_valid, err_tmo}, 2'b10);
    tick();
    check("tmo_set", {tx_valid, err_tmo, tx_level}, {1'b0, 1'b1, 4'd0});
    clr_err = 1; tick();
    clr_err = 0;
    check("tmo_clr", err_tmo, 0);

    // Unexpected strobe in IDLE, then reset during WAIT_DONE.
    rx_valid = 1; rx_data = 32'hBAD0_0000; tick();
    rx_valid = 0;
    check("ovf_set", {err_ovf, rx_level}, {1'b1, 4'd7});
    clr_err = 1; tick();
    clr_err = 0;
    host_wvalid = 1; host_wdata = 32'h5555_AAAA; enable = 1; tick();
    host_wvalid = 0; tick();
    enable = 0; tx_ready = 0; busy = 1; tick();
    check("wait_busy", q_busy, 1);
    arst_n = 0;
    model_reset();
    #1;
    check("arst_levels", {tx_level, rx_level}, 0);
    check("arst_outs", {host_wready, tx_valid, host_rvalid, err_tmo, err_ovf, q_busy}, 6'b100000);
    tick();
    arst_n = 1; busy = 0; tx_ready = 1;
    tick();

    // Randomized traffic in epochs with varying controller responsiveness.
    for (int ep = 0; ep < 6; ep++) begin
      int busy_pct = (ep % 3 == 0) ? 0 : ((ep % 3 == 1) ? 30 : 70);
      for (int c = 0; c < 600; c++) begin
        enable      = ($urandom_range(99) < 80);
        host_wvalid = ($urandom_range(99) < 50);
        host_wdata  = $urandom;
        host_rready = ($urandom_range(99) < 40);
        busy        = ($urandom_range(99) < busy_pct);
        tx_ready    = !busy || ($urandom_range(99) < 20);
        rx_valid    = ($urandom_range(99) < 20);
        rx_data     = $urandom;
        clr_err     = ($urandom_range(99) < 3);
        if ($urandom_range(799) == 0) begin
          arst_n = 0;
          model_reset();
          tick();
          arst_n = 1;
        end else begin
          tick();
        end
      end
    end

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
